// File: rtl/digital_lock_pkg.sv
// Shared types and constants for the two-button combination lock.
package digital_lock_pkg;

  localparam int unsigned STATE_W  = 2;
  localparam int unsigned CODE_LEN = 3;

  typedef enum logic [STATE_W-1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  // Bit i selects the button of press i (0 = w0, 1 = w1); sequence w0, w1, w1.
  localparam logic [CODE_LEN-1:0] CODE = 3'b110;

endpackage

// File: rtl/lock_press_detect.sv
// Rising-edge press detector for one button level; a held button counts once.
module lock_press_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_c_o
);

  logic p_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= 1'b0;
    end else begin
      p_q <= btn_i;
    end
  end

  assign press_c_o = btn_i & ~p_q;

endmodule

// File: rtl/digital_lock_fsm.sv
// Moore combination lock: unlocks after presses w0, w1, w1 with no wrong press.
module digital_lock_fsm
  import digital_lock_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic w0,
  input  logic w1,
  output logic L
);

  logic   pr0;
  logic   pr1;
  logic   hit_w0;
  logic   hit_w1;
  logic   hit_both;
  state_t state;
  state_t state_d;

  lock_press_detect u_det_w0 (
    .clk       (clk),
    .reset     (reset),
    .btn_i     (w0),
    .press_c_o (pr0)
  );

  lock_press_detect u_det_w1 (
    .clk       (clk),
    .reset     (reset),
    .btn_i     (w1),
    .press_c_o (pr1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
    end else begin
      state <= state_d;
    end
  end

  // A matching press advances; a stray w0 restarts the code; anything else relocks.
  always_comb begin
    state_d  = state;
    hit_w0   = pr0 & ~pr1;
    hit_w1   = pr1 & ~pr0;
    hit_both = pr0 & pr1;
    if (hit_both) begin
      state_d = S0;
    end else if (hit_w0 || hit_w1) begin
      if ((state != S3) && (CODE[state] == hit_w1)) begin
        state_d = state_t'(STATE_W'(state) + STATE_W'(1));
      end else if (hit_w0) begin
        state_d = S1;
      end else begin
        state_d = S0;
      end
    end
  end

  assign L = (state == S3);

endmodule

// File: tb/tb_digital_lock_fsm.sv
// Scenario bench for digital_lock_fsm; each row is {reset, w0, w1, expected state}.
module tb_digital_lock_fsm;

  logic clk;
  logic reset;
  logic w0;
  logic w1;
  logic L;

  int unsigned checks;
  int unsigned errors;
  logic [1:0]  exp_q [$];

  digital_lock_fsm dut (
    .clk   (clk),
    .reset (reset),
    .w0    (w0),
    .w1    (w1),
    .L     (L)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic a, input logic b);
    @(negedge clk);
    reset = r;
    w0    = a;
    w1    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit [4:0]   seq [4] = '{5'b1_10_00, 5'b1_10_00, 5'b0_10_01, 5'b0_00_01};
    logic [1:0] exp;
    logic [1:0] st;
    foreach (seq[i]) begin
      exp_q.push_back(seq[i][1:0]);
      drive(seq[i][4], seq[i][3], seq[i][2]);
      exp = exp_q.pop_front();
      st  = dut.state;
      checks++;
      if (st !== exp || L !== (exp == 2'b11)) begin
        errors++;
        $display("FAIL reset[%0d] state=%b L=%b expected state=%b L=%b", i, st, L, exp, exp == 2'b11);
      end
    end
  endtask

  task automatic test_code();
    bit [4:0]   seq [8] = '{5'b1_00_00, 5'b0_10_01, 5'b0_00_01, 5'b0_01_10,
                            5'b0_00_10, 5'b0_01_11, 5'b0_00_11, 5'b0_00_11};
    logic [1:0] exp;
    logic [1:0] st;
    foreach (seq[i]) begin
      exp_q.push_back(seq[i][1:0]);
      drive(seq[i][4], seq[i][3], seq[i][2]);
      exp = exp_q.pop_front();
      st  = dut.state;
      checks++;
      if (st !== exp || L !== (exp == 2'b11)) begin
        errors++;
        $display("FAIL code[%0d] state=%b L=%b expected state=%b L=%b", i, st, L, exp, exp == 2'b11);
      end
    end
  endtask

  task automatic test_relock();
    bit [4:0]   seq [6] = '{5'b0_10_01, 5'b0_00_01, 5'b0_01_10,
                            5'b0_00_10, 5'b0_01_11, 5'b0_00_11};
    logic [1:0] exp;
    logic [1:0] st;
    foreach (seq[i]) begin
      exp_q.push_back(seq[i][1:0]);
      drive(seq[i][4], seq[i][3], seq[i][2]);
      exp = exp_q.pop_front();
      st  = dut.state;
      checks++;
      if (st !== exp || L !== (exp == 2'b11)) begin
        errors++;
        $display("FAIL relock[%0d] state=%b L=%b expected state=%b L=%b", i, st, L, exp, exp == 2'b11);
      end
    end
  endtask

  task automatic test_wrong_entry();
    bit [4:0]   seq [13] = '{5'b1_00_00, 5'b0_01_00, 5'b0_00_00, 5'b0_10_01, 5'b0_00_01,
                             5'b0_10_01, 5'b0_00_01, 5'b0_10_01, 5'b0_00_01, 5'b0_01_10,
                             5'b0_00_10, 5'b0_01_11, 5'b0_00_11};
    logic [1:0] exp;
    logic [1:0] st;
    foreach (seq[i]) begin
      exp_q.push_back(seq[i][1:0]);
      drive(seq[i][4], seq[i][3], seq[i][2]);
      exp = exp_q.pop_front();
      st  = dut.state;
      checks++;
      if (st !== exp || L !== (exp == 2'b11)) begin
        errors++;
        $display("FAIL wrong[%0d] state=%b L=%b expected state=%b L=%b", i, st, L, exp, exp == 2'b11);
      end
    end
  endtask

  task automatic test_held();
    bit [4:0]   seq [11] = '{5'b1_00_00, 5'b0_10_01, 5'b0_10_01, 5'b0_10_01, 5'b0_10_01,
                             5'b0_10_01, 5'b0_00_01, 5'b0_01_10, 5'b0_00_10, 5'b0_01_11,
                             5'b0_00_11};
    logic [1:0] exp;
    logic [1:0] st;
    foreach (seq[i]) begin
      exp_q.push_back(seq[i][1:0]);
      drive(seq[i][4], seq[i][3], seq[i][2]);
      exp = exp_q.pop_front();
      st  = dut.state;
      checks++;
      if (st !== exp || L !== (exp == 2'b11)) begin
        errors++;
        $display("FAIL held[%0d] state=%b L=%b expected state=%b L=%b", i, st, L, exp, exp == 2'b11);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit [4:0]   seq [7] = '{5'b1_00_00, 5'b0_10_01, 5'b0_00_01, 5'b0_01_10,
                            5'b0_00_10, 5'b0_11_00, 5'b0_00_00};
    logic [1:0] exp;
    logic [1:0] st;
    foreach (seq[i]) begin
      exp_q.push_back(seq[i][1:0]);
      drive(seq[i][4], seq[i][3], seq[i][2]);
      exp = exp_q.pop_front();
      st  = dut.state;
      checks++;
      if (st !== exp || L !== (exp == 2'b11)) begin
        errors++;
        $display("FAIL both[%0d] state=%b L=%b expected state=%b L=%b", i, st, L, exp, exp == 2'b11);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit [4:0]   seq [9] = '{5'b1_00_00, 5'b0_10_01, 5'b0_00_01, 5'b0_01_10, 5'b0_00_10,
                            5'b1_01_00, 5'b0_00_00, 5'b0_01_00, 5'b0_00_00};
    logic [1:0] exp;
    logic [1:0] st;
    foreach (seq[i]) begin
      exp_q.push_back(seq[i][1:0]);
      drive(seq[i][4], seq[i][3], seq[i][2]);
      exp = exp_q.pop_front();
      st  = dut.state;
      checks++;
      if (st !== exp || L !== (exp == 2'b11)) begin
        errors++;
        $display("FAIL rstmid[%0d] state=%b L=%b expected state=%b L=%b", i, st, L, exp, exp == 2'b11);
      end
    end
  endtask

  // Presses on adjacent edges, and a w0 press while w1 is still held.
  task automatic test_back_to_back();
    bit [4:0]   seq [8] = '{5'b1_00_00, 5'b0_10_01, 5'b0_01_10, 5'b0_00_10,
                            5'b0_01_11, 5'b0_11_01, 5'b0_01_01, 5'b0_00_01};
    logic [1:0] exp;
    logic [1:0] st;
    foreach (seq[i]) begin
      exp_q.push_back(seq[i][1:0]);
      drive(seq[i][4], seq[i][3], seq[i][2]);
      exp = exp_q.pop_front();
      st  = dut.state;
      checks++;
      if (st !== exp || L !== (exp == 2'b11)) begin
        errors++;
        $display("FAIL b2b[%0d] state=%b L=%b expected state=%b L=%b", i, st, L, exp, exp == 2'b11);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    w0     = 1'b0;
    w1     = 1'b0;
    test_reset();
    test_code();
    test_relock();
    test_wrong_entry();
    test_held();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digital_lock_fsm.md
Name: digital_lock_fsm

Overview:
- Sequence-detecting combination lock with two push-buttons, w0 and w1.
- Asserts unlock output L after the code press-w0, press-w1, press-w1 is entered with no wrong press in between.
- Sits between debounced button synchronisers and the latch actuator.
- Moore machine: L depends only on the state register.

Parameters:
- None. The code sequence (w0, w1, w1) and the 2-bit state encoding are fixed constants.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; forces the lock to S0 on the next rising edge.
- w0  input  1  button 0 level; 1 = pressed; synchronous to clk.
- w1  input  1  button 1 level; 1 = pressed; synchronous to clk.
- L  output  1  1 = unlocked (state S3), 0 = locked.

Behaviour:
- The internal state register is named state, is 2 bits wide and is hierarchically visible to the bench.
- Encoding: S0=2'b00 idle, S1=2'b01 got w0, S2=2'b10 got w0,w1, S3=2'b11 unlocked.
- Press detection: a press is a 0->1 transition of a button level, sampled at a clock edge.
- Registers p0 and p1 hold the previous sampled levels.
- pr0 = w0 & ~p0, and pr1 = w1 & ~p1.
- A button held high for many cycles counts as exactly one press.
- Inputs held high for a single cycle must be detected.
- Classification of a cycle's presses:
  - Valid w0: pr0 & ~pr1.
  - Valid w1: pr1 & ~pr0.
  - Both: pr0 & pr1, treated as a wrong press.
  - None: neither pr0 nor pr1; the state holds.
- Transitions, evaluated at the same edge that samples the press:
  - S0: w0 -> S1; w1 or both -> S0.
  - S1: w1 -> S2; w0 -> S1 (a fresh code start); both -> S0.
  - S2: w1 -> S3; w0 -> S1; both -> S0.
  - S3: w0 -> S1 (relock and restart); w1 or both -> S0 (relock).
- Latency: state and L update at the edge where the press is sampled; no additional pipeline.
- Output: L = (state == S3), registered-state decode with no combinational path from w0/w1 to L.
- Reset:
  - At the edge where reset=1: state <= S0, p0 <= 0, p1 <= 0.
  - Consequently L=0 from the next edge.
  - Reset overrides any simultaneous press.
  - Reset in any state, including S3 or mid-entry, discards partial progress.
- After reset deasserts, a button already held high counts as a press on the first non-reset edge, because p0/p1 were cleared.
- No timeout: the machine waits indefinitely in S1, S2 and S3.
- L stays 1 until a press or reset.

Decomposition:
- Package digital_lock_pkg holds:
  - State enum S0..S3 with the encodings above.
  - Code constant describing the sequence (w0, w1, w1).
- One sub-module is natural: lock_press_detect.
  - Per-button rising-edge detector holding the p register.
  - Has a synchronous reset.
  - Instantiated twice.
- Next-state logic and the L decode stay in digital_lock_fsm.

Test Plan:
- Reset then code: reset=1 for one edge.
  - Then pulse w0, low, w1, low, w1, low (each one clock period).
  - Required: state 00->01->10->11, and L=1 after the third press edge.
- Relock from S3: from S3, pulse w0 -> state=01 and L=0; then pulse w1, w1 -> L=1 again.
- Wrong entry: from S0, pulse w1 -> state stays 00.
  - Pulse w0, w0 -> state=01.
  - Pulse w0 then w1, w1 -> L=1.
- Held button: hold w0=1 for five cycles, then pulse w1 twice.
  - Required: state 01 throughout the hold, L=1 after the second w1.
- Simultaneous press: from S2, assert w0=w1=1 for one cycle -> state=00 and L=0.
- Reset mid-operation: reach S2, assert reset with w1=1 on the same edge -> state=00 and L=0.
  - Release reset and pulse w1 -> state stays 00.
